mem_copy_master: RTL and testbench
==================================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter: DW, 16, data word width of the memory bus.
REQ-002 Parameter: AW, 9, address width; address space wraps mod 2^AW.
REQ-003 The clock is clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 src_addr  input  AW  first source word address; latched on accepted start.
REQ-008 dst_addr  input  AW  first destination word address; latched on accepted start.
REQ-009 count  input  AW  number of words to copy; latched on accepted start.
REQ-010 mem_cmd  output  2  bus command: 2'b00 NONE, 2'b10 READ, 2'b01 WRITE.
REQ-011 mem_addr  output  AW  bus address.
REQ-012 write_data  output  DW  data driven with WRITE.
REQ-013 read_data  input  DW  bus read data; valid one clk after READ is first presented.
REQ-014 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-015 done  output  1  one-cycle pulse on completion.

Function
REQ-016 The FSM states shall be IDLE, RD_ADDR, RD_WAIT, WR and DONE.
REQ-017 IDLE: mem_cmd=NONE; on start=1, latch the inputs and clear the word index i; go to DONE if count==0, otherwise go to RD_ADDR.
REQ-018 RD_ADDR: mem_cmd=READ, mem_addr=src+i; next state RD_WAIT.
REQ-019 RD_WAIT: mem_cmd=READ and mem_addr=src+i held; capture read_data into the data register at the clock edge; next state WR.
REQ-020 WR: mem_cmd=WRITE, mem_addr=dst+i, write_data=captured word; at the edge, i<=i+1; go to DONE if i+1==count, otherwise go to RD_ADDR.
REQ-021 DONE: mem_cmd=NONE, done=1 for exactly one cycle; next state IDLE.
REQ-022 Each word shall take exactly 3 cycles; a transfer of N>0 words shall take 3N+1 cycles from the first RD_ADDR through DONE.
REQ-023 Address sums (src+i, dst+i) shall be computed mod 2^AW: 9'h1FF+1 wraps to 9'h000.
REQ-024 Overlapping src/dst regions shall be copied in ascending order with no hazard protection (read-before-write per word only).
REQ-025 start asserted in any non-IDLE state shall be ignored, with no effect on the latched inputs.
REQ-026 Input changes after acceptance shall not affect the transfer in progress.
REQ-027 busy shall be high in RD_ADDR, RD_WAIT, WR and DONE, and low in IDLE.
REQ-028 write_data shall hold the last captured word when mem_cmd is not WRITE.
REQ-029 mem_addr shall be 0 in IDLE and DONE.
REQ-030 Only the encodings 00, 10 and 01 shall ever appear on mem_cmd.

Reset
REQ-031 On reset=1 at a clk edge, the state shall go to IDLE, i=0, and the data register and latched inputs shall be cleared.
REQ-032 Outputs after reset: mem_cmd=2'b00, mem_addr=0, write_data=0, busy=0, done=0.
REQ-033 Reset mid-transfer shall abort immediately, with no further WRITE issued; the next cycle is IDLE.
REQ-034 reset shall take priority over start in the same cycle.

Verification
REQ-035 RAM model preloaded at 0x010..0x012={16'hA1,16'hB2,16'hC3}; start with src=0x010, dst=0x080, count=3 -> three READ/READ/WRITE triplets, RAM 0x080..0x082 = A1,B2,C3, done pulse on cycle 10 after start, busy low afterwards.
REQ-036 count=0 with start -> the next state is DONE, done pulses once, mem_cmd stays NONE, no RAM change.
REQ-037 src=0x1FF, dst=0x0FE, count=2 -> reads 0x1FF then 0x000; writes 0x0FE then 0x0FF.
REQ-038 start re-asserted with different inputs during a transfer -> the original transfer completes unchanged, and no second transfer starts unless start is high in IDLE.
REQ-039 Reset asserted in the first WR of a count=4 transfer -> that write is not issued, mem_cmd=00 the next cycle, busy=0, only words already written persist.
REQ-040 Bus monitor across all tests -> mem_cmd never 2'b11, and done is never high for two consecutive cycles.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Bus bundle for mem_copy_master: copy request/status signals plus the
// single-port memory bus (command, address, write data, read data).
interface mem_copy_master_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] count;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          busy;
  logic          done;

  // The copy engine drives the memory bus and status
  modport master (
    input  start, src_addr, dst_addr, count, read_data,
    output mem_cmd, mem_addr, write_data, busy, done
  );

  // Requester plus memory side of the same bundle
  modport slave (
    output start, src_addr, dst_addr, count, read_data,
    input  mem_cmd, mem_addr, write_data, busy, done
  );
endinterface

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine. Each word takes three cycles
// (present read, capture read data, write), copying in ascending order
// with addresses wrapping modulo 2^AW.
module mem_copy_master #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input logic               clk,
  input logic               reset,
  mem_copy_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR, DONE} state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] idx;
  logic [DW-1:0] data_q;
  logic [AW-1:0] idx_next;
  logic [AW-1:0] src_sum;
  logic [AW-1:0] dst_sum;

  assign idx_next       = idx + 1'b1;
  assign src_sum        = src_q + idx;
  assign dst_sum        = dst_q + idx;
  assign bus.write_data = data_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latching, word index and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      idx    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q <= bus.src_addr;
            dst_q <= bus.dst_addr;
            cnt_q <= bus.count;
            idx   <= '0;
          end
        end
        RD_WAIT: data_q <= bus.read_data;
        WR:      idx    <= idx_next;
        default: ;
      endcase
    end
  end

  // Next state and bus outputs; reset also squashes the command this
  // cycle so an aborted write never reaches memory
  always_comb begin
    state_next   = state;
    bus.mem_cmd  = CMD_NONE;
    bus.mem_addr = '0;
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    case (state)
      IDLE: begin
        if (bus.start) state_next = (bus.count == '0) ? DONE : RD_ADDR;
      end
      RD_ADDR: begin
        bus.mem_cmd  = CMD_READ;
        bus.mem_addr = src_sum;
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        bus.mem_cmd  = CMD_READ;
        bus.mem_addr = src_sum;
        state_next   = WR;
      end
      WR: begin
        bus.mem_cmd  = CMD_WRITE;
        bus.mem_addr = dst_sum;
        state_next   = (idx_next == cnt_q) ? DONE : RD_ADDR;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) bus.mem_cmd = CMD_NONE;
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: a table of per-cycle vectors
// for a normal copy and a zero-length copy, then hand-written sequences
// for address wrap, ignored re-start and reset abort, against a RAM model.
module tb_mem_copy_master;

  localparam int DW = 16;
  localparam int AW = 9;

  typedef struct {
    logic          rst;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] cnt;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          busy;
    logic          done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   applied = 0;
  int   miscompares = 0;
  int   wr_cnt = 0;
  logic done_prev = 1'b0;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_q = '0;
  vec_t tbl[$];

  mem_copy_master_if #(.DW(DW), .AW(AW)) bus ();

  mem_copy_master #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.read_data = rd_q;

  // RAM model: registered read data, write on WRITE command
  always @(posedge clk) begin
    if (bus.mem_cmd == 2'b10) rd_q <= ram[bus.mem_addr];
    else if (bus.mem_cmd == 2'b01) begin
      ram[bus.mem_addr] <= bus.write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Bus monitor: illegal command encoding and stretched done pulse
  always @(negedge clk) begin
    if (bus.mem_cmd === 2'b11) begin
      miscompares++;
      $display("[TB] FAIL monitor mem_cmd: got %b, must never be 11", bus.mem_cmd);
    end
    if (bus.done === 1'b1 && done_prev === 1'b1) begin
      miscompares++;
      $display("[TB] FAIL monitor done: high two cycles in a row, expected single pulse");
    end
    done_prev <= bus.done;
  end

  function automatic vec_t mk(logic r, logic s, logic [AW-1:0] sa, logic [AW-1:0] da,
                              logic [AW-1:0] c, logic [1:0] ec, logic [AW-1:0] ea,
                              logic [DW-1:0] ew, logic eb, logic ed);
    vec_t v;
    v.rst = r;  v.start = s; v.src = sa; v.dst = da; v.cnt = c;
    v.cmd = ec; v.addr = ea; v.wd = ew;  v.busy = eb; v.done = ed;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset        = v.rst;
    bus.start    = v.start;
    bus.src_addr = v.src;
    bus.dst_addr = v.dst;
    bus.count    = v.cnt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    applied++;
    if (bus.mem_cmd !== v.cmd) begin
      miscompares++;
      $display("[TB] FAIL %s mem_cmd: got %b expected %b", tag, bus.mem_cmd, v.cmd);
    end
    if (bus.mem_addr !== v.addr) begin
      miscompares++;
      $display("[TB] FAIL %s mem_addr: got %h expected %h", tag, bus.mem_addr, v.addr);
    end
    if (bus.write_data !== v.wd) begin
      miscompares++;
      $display("[TB] FAIL %s write_data: got %h expected %h", tag, bus.write_data, v.wd);
    end
    if (bus.busy !== v.busy) begin
      miscompares++;
      $display("[TB] FAIL %s busy: got %b expected %b", tag, bus.busy, v.busy);
    end
    if (bus.done !== v.done) begin
      miscompares++;
      $display("[TB] FAIL %s done: got %b expected %b", tag, bus.done, v.done);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  task automatic checkRam(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge clk);
    applied++;
    if (ram[a] !== e) begin
      miscompares++;
      $display("[TB] FAIL %s ram[%h]: got %h expected %h", tag, a, ram[a], e);
    end
  endtask

  task automatic checkWrites(input string tag, input int e);
    applied++;
    if (wr_cnt != e) begin
      miscompares++;
      $display("[TB] FAIL %s write count: got %0d expected %0d", tag, wr_cnt, e);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
    ram[9'h010] = 16'h00A1; ram[9'h011] = 16'h00B2; ram[9'h012] = 16'h00C3;
    ram[9'h1FF] = 16'h1234; ram[9'h000] = 16'h5678;
    ram[9'h020] = 16'h1111; ram[9'h021] = 16'h2222;
    ram[9'h040] = 16'h4444; ram[9'h041] = 16'h5555;
    ram[9'h042] = 16'h6666; ram[9'h043] = 16'h7777;

    reset = 1'b1; bus.start = 1'b1;
    bus.src_addr = '0; bus.dst_addr = '0; bus.count = 9'd3;
    repeat (3) @(negedge clk);

    // Reset state, normal 3-word copy (done on cycle 10), zero-length copy
    tbl.push_back(mk(0,0,9'h000,9'h000,9'd0, 2'b00,9'h000,16'h0000,0,0));
    tbl.push_back(mk(0,1,9'h010,9'h080,9'd3, 2'b00,9'h000,16'h0000,0,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h010,16'h0000,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h010,16'h0000,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b01,9'h080,16'h00A1,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h011,16'h00A1,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h011,16'h00A1,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b01,9'h081,16'h00B2,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h012,16'h00B2,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b10,9'h012,16'h00B2,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b01,9'h082,16'h00C3,1,0));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b00,9'h000,16'h00C3,1,1));
    tbl.push_back(mk(0,0,9'h010,9'h080,9'd3, 2'b00,9'h000,16'h00C3,0,0));
    tbl.push_back(mk(0,1,9'h055,9'h066,9'd0, 2'b00,9'h000,16'h00C3,0,0));
    tbl.push_back(mk(0,0,9'h055,9'h066,9'd0, 2'b00,9'h000,16'h00C3,1,1));
    tbl.push_back(mk(0,0,9'h055,9'h066,9'd0, 2'b00,9'h000,16'h00C3,0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      applyStimulus(tbl[k]);
      checkOutput($sformatf("vec%0d", k), tbl[k]);
      if (k == 12) checkWrites("copy3", 3);
    end
    checkWrites("count0", 3);
    checkRam("copy3", 9'h080, 16'h00A1);
    checkRam("copy3", 9'h081, 16'h00B2);
    checkRam("copy3", 9'h082, 16'h00C3);

    // Address wrap on both source and destination
    step("wrap0", mk(0,1,9'h1FF,9'h0FE,9'd2, 2'b00,9'h000,16'h00C3,0,0));
    step("wrap1", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b10,9'h1FF,16'h00C3,1,0));
    step("wrap2", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b10,9'h1FF,16'h00C3,1,0));
    step("wrap3", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b01,9'h0FE,16'h1234,1,0));
    step("wrap4", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b10,9'h000,16'h1234,1,0));
    step("wrap5", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b10,9'h000,16'h1234,1,0));
    step("wrap6", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b01,9'h0FF,16'h5678,1,0));
    step("wrap7", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b00,9'h000,16'h5678,1,1));
    step("wrap8", mk(0,0,9'h1FF,9'h0FE,9'd2, 2'b00,9'h000,16'h5678,0,0));
    checkRam("wrap", 9'h0FE, 16'h1234);
    checkRam("wrap", 9'h0FF, 16'h5678);
    checkWrites("wrap", 5);

    // start held high with new inputs while busy must be ignored
    step("rest0", mk(0,1,9'h020,9'h0A0,9'd2, 2'b00,9'h000,16'h5678,0,0));
    step("rest1", mk(0,1,9'h030,9'h0C0,9'd5, 2'b10,9'h020,16'h5678,1,0));
    step("rest2", mk(0,1,9'h030,9'h0C0,9'd5, 2'b10,9'h020,16'h5678,1,0));
    step("rest3", mk(0,1,9'h030,9'h0C0,9'd5, 2'b01,9'h0A0,16'h1111,1,0));
    step("rest4", mk(0,1,9'h030,9'h0C0,9'd5, 2'b10,9'h021,16'h1111,1,0));
    step("rest5", mk(0,1,9'h030,9'h0C0,9'd5, 2'b10,9'h021,16'h1111,1,0));
    step("rest6", mk(0,1,9'h030,9'h0C0,9'd5, 2'b01,9'h0A1,16'h2222,1,0));
    step("rest7", mk(0,1,9'h030,9'h0C0,9'd5, 2'b00,9'h000,16'h2222,1,1));
    step("rest8", mk(0,0,9'h030,9'h0C0,9'd5, 2'b00,9'h000,16'h2222,0,0));
    step("rest9", mk(0,0,9'h030,9'h0C0,9'd5, 2'b00,9'h000,16'h2222,0,0));
    checkRam("restart", 9'h0A0, 16'h1111);
    checkRam("restart", 9'h0A1, 16'h2222);
    checkRam("restart", 9'h0C0, 16'h0000);
    checkWrites("restart", 7);

    // Reset (with start also high) during the first WR of a 4-word copy
    step("abort0", mk(0,1,9'h040,9'h0E0,9'd4, 2'b00,9'h000,16'h2222,0,0));
    step("abort1", mk(0,0,9'h040,9'h0E0,9'd4, 2'b10,9'h040,16'h2222,1,0));
    step("abort2", mk(0,0,9'h040,9'h0E0,9'd4, 2'b10,9'h040,16'h2222,1,0));
    step("abort3", mk(1,1,9'h040,9'h0E0,9'd4, 2'b00,9'h0E0,16'h4444,1,0));
    step("abort4", mk(0,0,9'h040,9'h0E0,9'd4, 2'b00,9'h000,16'h0000,0,0));
    step("abort5", mk(0,0,9'h040,9'h0E0,9'd4, 2'b00,9'h000,16'h0000,0,0));
    checkRam("abort", 9'h0E0, 16'h0000);
    checkWrites("abort", 7);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
